// File: rtl/kernel_loader_pkg.sv
// Shared types for the kernel loader: FSM state encoding and kernel register address.
package kernel_loader_pkg;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef logic [ADDR_W-1:0] kaddr_t;
endpackage

// File: rtl/kernel_loader_if.sv
// Coefficient stream in, kernel register file write port out.
interface kernel_loader_if #(parameter int WIDTH = 16);
  import kernel_loader_pkg::*;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  kaddr_t           write_addr;
  logic             write_en;
  logic [WIDTH-1:0] din;

  modport master (
    input  in_data, in_valid,
    output in_ready, write_addr, write_en, din
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, write_addr, write_en, din
  );
endinterface

// File: rtl/kernel_loader_tap_counter.sv
// Tap index counter; saturates at NUM_TAPS-1 so it can never wrap.
module tap_counter
  import kernel_loader_pkg::*;
#(
  parameter int NUM_TAPS = 9
) (
  input  logic   clk,
  input  logic   arst,
  input  logic   clear,
  input  logic   enable,
  output kaddr_t count,
  output logic   tc
);
  localparam kaddr_t LAST = kaddr_t'(NUM_TAPS - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                count <= '0;
    else if (clear)          count <= '0;
    else if (enable && !tc)  count <= count + kaddr_t'(1);
  end
endmodule

// File: rtl/kernel_loader.sv
// Loads NUM_TAPS coefficients from a valid/ready stream into the kernel register file.
module kernel_loader
  import kernel_loader_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_TAPS = 9
) (
  input  logic clk,
  input  logic arst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic loaded,
  kernel_loader_if.master bus
);
  state_t state, state_nxt;
  kaddr_t count;
  logic   tc, hs, launch;

  assign hs     = bus.in_valid & bus.in_ready;
  assign launch = (state == IDLE) & start & ~abort;

  tap_counter #(.NUM_TAPS(NUM_TAPS)) u_tap_counter (
    .clk    (clk),
    .arst   (arst),
    .clear  (launch),
    .enable (hs),
    .count  (count),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = LOAD;
      LOAD:    if (abort) state_nxt = IDLE;
               else if (hs && tc) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FLUSH is exactly the cycle the final registered write is visible.
  always_comb begin
    bus.in_ready = (state == LOAD);
    busy         = (state != IDLE);
    done         = (state == FLUSH) & ~abort;
  end

  // A handshake that coincides with abort was already accepted, so it is still written.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bus.write_en   <= 1'b0;
      bus.write_addr <= '0;
      bus.din        <= '0;
    end else begin
      bus.write_en <= hs;
      if (hs) begin
        bus.write_addr <= count;
        bus.din        <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                            loaded <= 1'b0;
    else if (launch)                     loaded <= 1'b0;
    else if (state == FLUSH && !abort)   loaded <= 1'b1;
  end
endmodule

// File: tb/tb_kernel_loader.sv
// Drives a 9-tap and a 1-tap loader with shared stimulus; a negedge monitor scores both.
module tb_kernel_loader;
  localparam int W = 16;

  typedef struct {
    int           addr;
    logic [W-1:0] data;
    bit           done;
  } exp_t;

  localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2;

  logic         clk = 1'b0;
  logic         arst, start, abort, in_valid;
  logic [W-1:0] in_data;
  logic         busy9, done9, loaded9, busy1, done1, loaded1;

  always #5 clk = ~clk;

  kernel_loader_if #(.WIDTH(W)) b9 ();
  kernel_loader_if #(.WIDTH(W)) b1 ();

  assign b9.in_data  = in_data;
  assign b9.in_valid = in_valid;
  assign b1.in_data  = in_data;
  assign b1.in_valid = in_valid;

  kernel_loader #(.WIDTH(W), .NUM_TAPS(9)) dut9 (
    .clk(clk), .arst(arst), .start(start), .abort(abort),
    .busy(busy9), .done(done9), .loaded(loaded9), .bus(b9.master)
  );

  kernel_loader #(.WIDTH(W), .NUM_TAPS(1)) dut1 (
    .clk(clk), .arst(arst), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .loaded(loaded1), .bus(b1.master)
  );

  // Reference model: what each load should produce, in terms of the protocol rules.
  exp_t q0[$], q1[$];
  int   ph[2], idx[2];
  bit   mld[2], e_ready[2], e_busy[2], e_loaded[2];
  bit   final_chk = 1'b0;
  int   checks = 0, errors = 0;

  function automatic int ntaps(input int d);
    return (d == 0) ? 9 : 1;
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic cycle(input bit s, input bit a, input bit v, input logic [W-1:0] dt, input bit r);
    exp_t e;
    arst = r; start = s; abort = a; in_valid = v; in_data = dt;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        ph[d] = P_IDLE; idx[d] = 0; mld[d] = 1'b0;
        e_ready[d] = 1'b0; e_busy[d] = 1'b0; e_loaded[d] = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        e_ready[d]  = (ph[d] == P_LOAD);
        e_busy[d]   = (ph[d] != P_IDLE);
        e_loaded[d] = mld[d];
        case (ph[d])
          P_IDLE: if (s && !a) begin ph[d] = P_LOAD; idx[d] = 0; mld[d] = 1'b0; end
          P_LOAD: begin
            if (v) begin
              e.addr = idx[d]; e.data = dt; e.done = (idx[d] == ntaps(d) - 1) && !a;
              push(d, e);
              if (idx[d] == ntaps(d) - 1) ph[d] = P_FLUSH;
              else idx[d]++;
            end
            if (a) ph[d] = P_IDLE;
          end
          default: begin
            if (a) begin
              if (d == 0 && q0.size() > 0) q0[q0.size()-1].done = 1'b0;
              if (d == 1 && q1.size() > 0) q1[q1.size()-1].done = 1'b0;
            end else mld[d] = 1'b1;
            ph[d] = P_IDLE;
          end
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic         we, rdy, bsy, dn, ld;
      logic [4:0]   wa;
      logic [W-1:0] wd;
      exp_t         e;
      we  = d ? b1.write_en   : b9.write_en;
      wa  = d ? b1.write_addr : b9.write_addr;
      wd  = d ? b1.din        : b9.din;
      rdy = d ? b1.in_ready   : b9.in_ready;
      bsy = d ? busy1   : busy9;
      dn  = d ? done1   : done9;
      ld  = d ? loaded1 : loaded9;
      if (arst) begin
        chk("reset_outputs", d, {we, wa, wd, rdy, bsy, dn, ld}, '0);
      end else begin
        chk("in_ready", d, rdy, e_ready[d]);
        chk("busy", d, bsy, e_busy[d]);
        chk("loaded", d, ld, e_loaded[d]);
        if (we) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) chk("extra_write", d, 1, 0);
          else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("write_addr", d, wa, e.addr);
            chk("din", d, wd, e.data);
            chk("done", d, dn, e.done);
          end
        end else chk("done_without_write", d, dn, 0);
      end
      if (final_chk) chk("pending_writes", d, (d == 0) ? q0.size() : q1.size(), 0);
    end
  end

  initial begin
    arst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int d = 0; d < 2; d++) begin
      ph[d] = P_IDLE; idx[d] = 0; mld[d] = 1'b0;
      e_ready[d] = 1'b0; e_busy[d] = 1'b0; e_loaded[d] = 1'b0;
    end
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 0);

    // Nominal back-to-back load
    cycle(1, 0, 0, '0, 0);
    for (int i = 1; i <= 9; i++) cycle(0, 0, 1, W'(i), 0);
    repeat (3) cycle(0, 0, 0, '0, 0);

    // Bubbled input: valid on alternate cycles
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 0, (i % 2) == 0, W'(16'h0100 + i / 2), 0);
    repeat (3) cycle(0, 0, 0, '0, 0);

    // Abort after the 4th handshake, then reload
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, W'(16'h0200 + i), 0);
    cycle(0, 1, 0, '0, 0);
    repeat (3) cycle(0, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, W'(16'h0300 + i), 0);
    repeat (2) cycle(0, 0, 0, '0, 0);

    // Start while busy at address 5 is ignored; first word 0xABCD for the 1-tap build
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 1, 16'hABCD, 0);
    for (int i = 1; i < 9; i++) cycle(i == 5, 0, 1, W'(16'h0400 + i), 0);
    repeat (2) cycle(0, 0, 0, '0, 0);

    // Long stall mid-load, then reset pulse during the address-6 handshake
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, W'(16'h0500 + i), 0);
    repeat (40) cycle(0, 0, 0, '0, 0);
    for (int i = 3; i < 6; i++) cycle(0, 0, 1, W'(16'h0500 + i), 0);
    cycle(0, 0, 1, 16'h0506, 1);
    repeat (3) cycle(0, 0, 1, 16'h0507, 0);
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, W'(16'h0600 + i), 0);
    repeat (2) cycle(0, 0, 0, '0, 0);

    // Abort together with start in idle, and abort with nothing running
    cycle(1, 1, 0, '0, 0);
    cycle(0, 1, 1, 16'h0700, 0);
    repeat (2) cycle(0, 0, 1, 16'h0701, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++)
      cycle(($urandom % 8) == 0, ($urandom % 25) == 0, ($urandom % 10) < 7,
            W'($urandom), ($urandom % 150) == 0);

    repeat (4) cycle(0, 0, 0, '0, 0);
    final_chk = 1'b1;
    cycle(0, 0, 0, '0, 0);
    final_chk = 1'b0;
    cycle(0, 0, 0, '0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, coefficient bit width.
REQ-002 SHALL have parameter NUM_TAPS, default 9, coefficients per kernel (legal range 1..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to load one kernel (sampled each cycle).
REQ-006 SHALL have port abort  input  1  cancels a load in progress.
REQ-007 SHALL have port in_data  input  WIDTH  coefficient stream payload.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-010 SHALL have port write_addr  output  5  kernel register file write address.
REQ-011 SHALL have port write_en  output  1  kernel register file write strobe.
REQ-012 SHALL have port din  output  WIDTH  kernel register file write data.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse; the last coefficient has been written.
REQ-015 SHALL have port loaded  output  1  a complete kernel is held in the register file.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FLUSH.
REQ-017 IDLE: start=1 -> LOAD; tap counter := 0; loaded := 0.
REQ-018 LOAD: in_ready=1. A handshake occurs when in_valid & in_ready are both 1.
REQ-019 Each handshake SHALL register write_en=1, din=in_data and write_addr=counter on the next edge; write latency is exactly 1 cycle.
REQ-020 On each handshake the counter SHALL increment by 1.
REQ-021 Handshake with counter == NUM_TAPS-1 -> FLUSH; counter SHALL NOT wrap past NUM_TAPS-1.
REQ-022 FLUSH: in_ready=0; on the cycle the last write_en is high, done=1 and loaded := 1; next state IDLE.
REQ-023 write_en SHALL be 0 on every cycle with no preceding handshake; din and write_addr hold their last values when write_en=0.
REQ-024 busy SHALL be 1 in LOAD and FLUSH, and 0 in IDLE.
REQ-025 in_valid=0 in LOAD SHALL stall without a timeout; the counter holds its value.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort in LOAD or FLUSH -> IDLE on the next edge. The pending registered write (if any) still completes. done is not pulsed and loaded stays 0.
REQ-028 abort and start in the same IDLE cycle: abort wins and start is ignored.
REQ-029 abort in IDLE SHALL have no effect, and loaded is unchanged.
REQ-030 Write addresses SHALL be issued strictly ascending 0..NUM_TAPS-1, each exactly once per completed load.
REQ-031 in_ready SHALL be derived from FSM state only, not combinationally from in_valid.

Reset
REQ-032 arst=1 SHALL immediately force state=IDLE and counter=0.
REQ-033 arst=1 SHALL immediately force write_en=0, write_addr=0, din=0, busy=0, done=0, loaded=0 and in_ready=0.
REQ-034 Reset asserted mid-load SHALL discard the partial load with no further write_en. After release the block waits in IDLE for start.

Structure
REQ-035 A shared package SHALL hold the FSM state enum type and the 5-bit kernel address typedef.
REQ-036 The tap counter SHALL be a separate sub-module tap_counter with clear, enable and terminal-count outputs. All other logic stays in kernel_loader.
REQ-037 The design SHALL contain no memories; all storage is flops.

Verification
REQ-038 Nominal load: start pulse, then 9 back-to-back valid words 0x0001..0x0009 -> write_en high 9 consecutive cycles, addresses 0..8, din 0x0001..0x0009, done pulse on the address-8 write, loaded=1.
REQ-039 Bubbled input: in_valid low on alternate cycles -> 9 writes spread over 17 cycles, correct addresses/data, no extra or duplicated write_en.
REQ-040 Abort: abort after the 4th handshake -> exactly 4 writes (addresses 0..3), no done, loaded=0, busy=0 two cycles later; a new start then reloads from address 0.
REQ-041 start during LOAD at address 5 -> ignored; load completes at address 8 with exactly 9 writes.
REQ-042 arst pulse during LOAD at address 6 -> all outputs 0 asynchronously; no write_en after reset; the next full load is correct.
REQ-043 NUM_TAPS=1 build: start plus one word 0xABCD -> a single write at address 0 with din=0xABCD, done pulse, loaded=1.
